// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI mode-3 transmit link between two requesters; ack in the grant cycle, ss low the next.
// Requesters hold req/data until ack; req is only looked at while idle, so a busy link simply leaves requests pending.
module spi_tx_arbiter #(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 500,
  parameter int GAP     = 4
) (
  input  logic             clk100M,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  output logic             done0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             done1,
  output logic             busy,
  output logic             sclk,
  output logic             mosi,
  output logic             ss
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_END = BW'(WIDTH);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bitcnt_q, bitcnt_n;
  logic [GW-1:0]    gapcnt_q, gapcnt_n;
  logic [WIDTH-1:0] shift_q, shift_n;
  logic [WIDTH-1:0] word;
  logic             sclk_q, sclk_n;
  logic             ss_q, ss_n;
  logic             mosi_q, mosi_n;
  logic             owner_q, owner_n;
  logic             ptr_q, ptr_n;
  logic             done0_q, done0_n;
  logic             done1_q, done1_n;
  logic             ack0_c, ack1_c;
  logic             sel;
  logic             tick;

  assign tick = (cnt_q == CNT_MAX);
  // When both request, ptr_q picks requester 1 only if requester 0 was served last.
  assign sel  = req1 && (!req0 || ptr_q);
  assign word = sel ? data1 : data0;

  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b1;
      ss_q     <= 1'b1;
      mosi_q   <= 1'b0;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      bitcnt_q <= bitcnt_n;
      gapcnt_q <= gapcnt_n;
      shift_q  <= shift_n;
      sclk_q   <= sclk_n;
      ss_q     <= ss_n;
      mosi_q   <= mosi_n;
      owner_q  <= owner_n;
      ptr_q    <= ptr_n;
      done0_q  <= done0_n;
      done1_q  <= done1_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    bitcnt_n = bitcnt_q;
    gapcnt_n = gapcnt_q;
    shift_n  = shift_q;
    sclk_n   = sclk_q;
    ss_n     = ss_q;
    mosi_n   = mosi_q;
    owner_n  = owner_q;
    ptr_n    = ptr_q;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
    ack0_c   = 1'b0;
    ack1_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ss_n   = 1'b1;
        sclk_n = 1'b1;
        mosi_n = 1'b0;
        if (req0 || req1) begin
          shift_n  = word;
          mosi_n   = word[WIDTH-1];
          owner_n  = sel;
          ptr_n    = !sel;
          ack0_c   = !sel;
          ack1_c   = sel;
          ss_n     = 1'b0;
          bitcnt_n = '0;
          state_n  = S_LEAD;
        end
      end
      S_LEAD: begin
        if (tick) begin
          sclk_n  = 1'b0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // MSB is already on mosi, so data only advances on the falling edges between bits.
        if (tick) begin
          if (!sclk_q) begin
            sclk_n   = 1'b1;
            bitcnt_n = bitcnt_q + 1'b1;
          end else if (bitcnt_q == BITS_END) begin
            state_n = S_TRAIL;
          end else begin
            sclk_n  = 1'b0;
            shift_n = {shift_q[WIDTH-2:0], 1'b0};
            mosi_n  = shift_q[WIDTH-2];
          end
        end
      end
      S_TRAIL: begin
        if (tick) begin
          ss_n     = 1'b1;
          mosi_n   = 1'b0;
          done0_n  = !owner_q;
          done1_n  = owner_q;
          gapcnt_n = '0;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gapcnt_q == GAP_END) begin
            state_n = S_IDLE;
          end else begin
            gapcnt_n = gapcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign ack0  = ack0_c;
  assign ack1  = ack1_c;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = (state_q != S_IDLE);
  assign sclk  = sclk_q;
  assign ss    = ss_q;
  assign mosi  = mosi_q;

  a_ack_excl: assert property (@(posedge clk100M) disable iff (!rst_n) !(ack0 && ack1));
  a_done_excl: assert property (@(posedge clk100M) disable iff (!rst_n) !(done0 && done1));
  a_ack_done: assert property (@(posedge clk100M) disable iff (!rst_n) !((ack0 || ack1) && (done0 || done1)));

endmodule
